// File: rtl/mem_subsys_pkg.sv
// Shared types and address helpers for the banked
// instruction/data memory subsystem.
package mem_subsys_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic {
    PORT_IM = 1'b0,
    PORT_DM = 1'b1
  } port_e;

  // Word-interleaved: low word bits pick the bank.
  function automatic logic [31:0] bank_of(
    input logic [31:0] addr,
    input int unsigned nb
  );
    return (addr >> 2) & (nb - 1);
  endfunction

  function automatic logic [31:0] row_of(
    input logic [31:0] addr,
    input int unsigned nb,
    input int unsigned depth
  );
    return ((addr >> 2) >> $clog2(nb)) & (depth - 1);
  endfunction

endpackage

// File: rtl/mem_subsys_sram_bank.sv
// Behavioural synchronous SRAM bank with active-low
// chip/write/bit-write enables and one-cycle read.
module sram_bank #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16384
) (
  input  logic                     clk,
  input  logic                     ceb,
  input  logic                     web,
  input  logic [DATA_W-1:0]        bweb,
  input  logic [$clog2(DEPTH)-1:0] row,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        q
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (!ceb) begin
      if (!web) begin
        mem[row] <= (mem[row] & bweb)
                  | (wdata & ~bweb);
      end else begin
        q <= mem[row];
      end
    end
  end

endmodule

// File: rtl/mem_subsys.sv
// Banked shared IM/DM memory: round-robin arbitration on
// same-bank conflicts, one-cycle read return per port.
module mem_subsys
  import mem_subsys_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int NUM_BANKS  = 2,
  parameter int BANK_DEPTH = 16384,
  parameter int FIRST_PRIO = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  im_req,
  input  logic [31:0]           im_addr,
  output logic                  im_gnt,
  output logic                  im_rvalid,
  output logic [DATA_W-1:0]     im_rdata,
  input  logic                  dm_req,
  input  logic                  dm_we,
  input  logic [DATA_W/8-1:0]   dm_be,
  input  logic [31:0]           dm_addr,
  input  logic [DATA_W-1:0]     dm_wdata,
  output logic                  dm_gnt,
  output logic                  dm_rvalid,
  output logic [DATA_W-1:0]     dm_rdata,
  output logic [31:0]           conflict_cnt
);

  localparam int BW  = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int RW  = $clog2(BANK_DEPTH);
  localparam int NBE = DATA_W / BYTE_W;
  localparam port_e RST_PRIO =
    (FIRST_PRIO != 0) ? PORT_DM : PORT_IM;

  logic [BW-1:0]     im_bank, dm_bank;
  logic [BW-1:0]     im_bank_q, dm_bank_q;
  logic [RW-1:0]     im_row, dm_row;
  logic [DATA_W-1:0] bweb;
  logic [DATA_W-1:0] im_hold, dm_hold;
  logic [DATA_W-1:0] bank_q [NUM_BANKS];
  logic              conflict;
  port_e             prio;

  assign im_bank = BW'(bank_of(im_addr, NUM_BANKS));
  assign dm_bank = BW'(bank_of(dm_addr, NUM_BANKS));
  assign im_row  = RW'(row_of(im_addr, NUM_BANKS, BANK_DEPTH));
  assign dm_row  = RW'(row_of(dm_addr, NUM_BANKS, BANK_DEPTH));

  assign conflict = ~rst & im_req & dm_req
                  & (im_bank == dm_bank);

  assign im_gnt = ~rst & im_req
                & (~conflict | (prio == PORT_IM));
  assign dm_gnt = ~rst & dm_req
                & (~conflict | (prio == PORT_DM));

  // Priority passes to the loser so nobody waits twice.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio <= RST_PRIO;
    end else if (conflict) begin
      prio <= (prio == PORT_IM) ? PORT_DM : PORT_IM;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_cnt <= '0;
    end else if (conflict && conflict_cnt != '1) begin
      conflict_cnt <= conflict_cnt + 32'd1;
    end
  end

  always_comb begin
    bweb = '1;
    for (int i = 0; i < NBE; i++) begin
      if (dm_be[i]) bweb[i*BYTE_W +: BYTE_W] = '0;
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic im_hit, dm_hit;

    assign im_hit = im_gnt & (im_bank == BW'(b));
    assign dm_hit = dm_gnt & (dm_bank == BW'(b));

    sram_bank #(
      .DATA_W (DATA_W),
      .DEPTH  (BANK_DEPTH)
    ) u_bank (
      .clk   (clk),
      .ceb   (~(im_hit | dm_hit)),
      .web   (~(dm_hit & dm_we)),
      .bweb  (dm_hit ? bweb : '1),
      .row   (dm_hit ? dm_row : im_row),
      .wdata (dm_wdata),
      .q     (bank_q[b])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      im_rvalid <= 1'b0;
      dm_rvalid <= 1'b0;
      im_hold   <= '0;
      dm_hold   <= '0;
    end else begin
      im_rvalid <= im_gnt;
      dm_rvalid <= dm_gnt & ~dm_we;
      if (im_rvalid) im_hold <= im_rdata;
      if (dm_rvalid) dm_hold <= dm_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (im_gnt) im_bank_q <= im_bank;
    if (dm_gnt) dm_bank_q <= dm_bank;
  end

  // Bank outputs move with other traffic, so hold between returns.
  assign im_rdata = im_rvalid ? bank_q[im_bank_q] : im_hold;
  assign dm_rdata = dm_rvalid ? bank_q[dm_bank_q] : dm_hold;

endmodule
